// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg -- shared types for the RV32I decode stage.
//
// Contents:
//   inst_t          : instruction format (R=0 I=1 S=2 SB=3 UJ=4 U=5)
//   OP_*            : major opcodes recognised by the decoder
//   decode_bundle_t : one fully decoded instruction. pc/imm are sized for the
//                     widest supported datapath (64 bits); a 32-bit stage uses
//                     only the low XLEN bits.
package rv_decode_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        INST_R  = 3'd0,
        INST_I  = 3'd1,
        INST_S  = 3'd2,
        INST_SB = 3'd3,
        INST_UJ = 3'd4,
        INST_U  = 3'd5
    } inst_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] imm;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        inst_t               inst_type;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic                illegal;
    } decode_bundle_t;

endpackage

// File: rtl/rv_inst_decode.sv
// rv_inst_decode -- purely combinational RV32I field extraction.
//
// Ports:
//   inst   in  32    instruction word
//   pc     in  XLEN  instruction address (zero-extended into the bundle)
//   bundle out       decoded fields, immediate sign-extended to 64 bits
//
// Unused register fields are forced to zero so downstream hazard logic never
// sees a phantom dependency. An unrecognised opcode yields an all-zero bundle
// apart from pc, opcode and the illegal flag.
module rv_inst_decode
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output decode_bundle_t  bundle
);

    logic [6:0] opcode;
    logic       sign;
    inst_t      fmt;
    logic       legal;

    assign opcode = inst[6:0];
    assign sign   = inst[31];

    // Every legal opcode ends in 2'b11, so a compressed-looking word
    // (inst[1:0] != 2'b11) lands in the default arm by construction.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        fmt   = INST_R;
        legal = 1'b1;
        case (opcode)
            OP_REG:                               fmt = INST_R;
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:  fmt = INST_I;
            OP_STORE:                             fmt = INST_S;
            OP_BRANCH:                            fmt = INST_SB;
            OP_JAL:                               fmt = INST_UJ;
            OP_LUI, OP_AUIPC:                     fmt = INST_U;
            default:                              legal = 1'b0;
        endcase
    end

    always_comb begin
        bundle         = '0;
        bundle.pc      = XLEN_MAX'(pc);
        bundle.opcode  = opcode;
        bundle.illegal = !legal;

        if (legal) begin
            bundle.inst_type = fmt;
            bundle.rs1    = (fmt == INST_U || fmt == INST_UJ) ? 5'd0 : inst[19:15];
            bundle.rs2    = (fmt == INST_I || fmt == INST_U || fmt == INST_UJ) ? 5'd0 : inst[24:20];
            bundle.rd     = (fmt == INST_S || fmt == INST_SB) ? 5'd0 : inst[11:7];
            bundle.funct3 = (fmt == INST_U || fmt == INST_UJ) ? 3'd0 : inst[14:12];
            bundle.funct7 = (fmt == INST_R) ? inst[31:25] : 7'd0;

            case (fmt)
                INST_I:  bundle.imm = {{52{sign}}, inst[31:20]};
                INST_S:  bundle.imm = {{52{sign}}, inst[31:25], inst[11:7]};
                INST_SB: bundle.imm = {{51{sign}}, inst[31], inst[7], inst[30:25],
                                       inst[11:8], 1'b0};
                INST_U:  bundle.imm = {{32{sign}}, inst[31:12], 12'h000};
                INST_UJ: bundle.imm = {{43{sign}}, inst[31], inst[19:12], inst[20],
                                       inst[30:21], 1'b0};
                default: bundle.imm = '0;
            endcase
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage -- registered RV32I decode stage between fetch and execute.
//
// Ports:
//   clk, nRst            clock, asynchronous active-low reset
//   flush                synchronous; drops everything held in the stage
//   if_valid/if_ready    fetch-side handshake, if_inst/if_pc carry the word
//   id_valid/id_ready    execute-side handshake
//   id_pc, id_imm        XLEN-wide pc and sign-extended immediate
//   id_rs1/rs2/rd        register indices, zero when the format has none
//   id_type              format code (R=0 I=1 S=2 SB=3 UJ=4 U=5)
//   id_opcode/funct3/7   raw opcode and funct fields
//   id_illegal           unsupported encoding
//
// Decoding happens before the registers, so both the output register and the
// skid register hold finished bundles. With SKID_EN=1 if_ready comes straight
// from a flop; the skid entry absorbs the one word fetch may send in the cycle
// the output stalls. With SKID_EN=0 there is no skid and if_ready is derived
// combinationally from id_ready.
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            nRst,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_imm,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [2:0]      id_type,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7,
    output logic            id_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    decode_bundle_t dec, out_q, skid_q;
    logic           if_ready_q;
    logic           accept;
    logic           load_out_dec, load_out_skid, load_skid;

    rv_inst_decode #(.XLEN(XLEN)) u_decode (
        .inst   (if_inst),
        .pc     (if_pc),
        .bundle (dec)
    );

    assign if_ready = SKID_EN ? if_ready_q : (state_q == ST_EMPTY || id_ready);
    assign accept   = if_valid && if_ready;

    always_comb begin
        state_d       = state_q;
        load_out_dec  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d      = ST_FULL;
                    load_out_dec = 1'b1;
                end
            end
            ST_FULL: begin
                if (id_ready) begin
                    if (accept) load_out_dec = 1'b1;
                    else        state_d      = ST_EMPTY;
                end else if (accept) begin
                    // Output is stalled: park the new bundle behind it.
                    state_d   = ST_SKID;
                    load_skid = 1'b1;
                end
            end
            ST_SKID: begin
                // if_ready is low here, so nothing new can arrive.
                if (id_ready) begin
                    state_d       = ST_FULL;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush wins over any same-cycle accept; the accepted word is lost.
        if (flush) begin
            state_d       = ST_EMPTY;
            load_out_dec  = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= ST_EMPTY;
            if_ready_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples values from before the edge, independent of order.
            state_q    <= state_d;
            if_ready_q <= (state_d != ST_SKID);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            // NOTE: the bundle registers are reset (not left to power-up
            // values) because every id_* output must read 0 during reset.
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_dec)       out_q <= dec;
            else if (load_out_skid) out_q <= skid_q;
            if (load_skid)          skid_q <= dec;
        end
    end

    assign id_valid   = (state_q != ST_EMPTY);
    assign id_pc      = out_q.pc[XLEN-1:0];
    assign id_imm     = out_q.imm[XLEN-1:0];
    assign id_rs1     = out_q.rs1;
    assign id_rs2     = out_q.rs2;
    assign id_rd      = out_q.rd;
    assign id_type    = out_q.inst_type;
    assign id_opcode  = out_q.opcode;
    assign id_funct3  = out_q.funct3;
    assign id_funct7  = out_q.funct7;
    assign id_illegal = out_q.illegal;

    // A 32-bit stage carries but never presents the upper bundle bits.
    if (XLEN < XLEN_MAX) begin : g_narrow
        logic unused_upper;
        assign unused_upper = ^{out_q.pc[XLEN_MAX-1:XLEN], out_q.imm[XLEN_MAX-1:XLEN]};
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV32I instruction decode stage between fetch and execute.
- Classifies the opcode into R/I/S/SB/UJ/U and flags illegal encodings.
- Extracts register indices and funct fields, and builds the sign-extended immediate for every format.
- Uses a valid/ready handshake on both sides, with a one-entry skid buffer so that `if_ready` is a registered signal; supports flush.

Parameters:
- XLEN, 32, datapath width of pc and immediate (32 or 64); immediates sign-extend to XLEN.
- SKID_EN, 1, 1 = skid buffer present (if_ready registered); 0 = if_ready = !out_valid | id_ready.

Ports:
- clk  in  1  clock
- nRst  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discards all held instructions
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage can accept
- if_inst  in  32  instruction word
- if_pc  in  XLEN  instruction address
- id_valid  out  1  decoded bundle valid
- id_ready  in  1  execute accepts bundle
- id_pc  out  XLEN  pc of bundle
- id_imm  out  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  out  5 each  register indices (zeroed when unused)
- id_type  out  3  R=0 I=1 S=2 SB=3 UJ=4 U=5
- id_opcode  out  7  inst[6:0]
- id_funct3  out  3  inst[14:12]; 0 for U/UJ
- id_funct7  out  7  inst[31:25] for R; 0 otherwise
- id_illegal  out  1  unsupported encoding

Behaviour:
- Reset (nRst low, async):
  - id_valid=0, if_ready=1 (SKID_EN=1), skid empty.
  - All id_* data outputs are 0.
- Classification (combinational on the incoming word):
  - 0110011 -> R.
  - 0000011, 0010011, 1100111, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> SB.
  - 1101111 -> UJ.
  - 0110111, 0010111 -> U.
  - Any other opcode, or inst[1:0]!=2'b11 -> id_illegal=1, id_type=R, and rs1/rs2/rd/funct/imm all 0.
  - Classification uses mutually exclusive priority, with no fall-through override.
- Field zeroing by format:
  - rs1=0 for U/UJ.
  - rs2=0 for I/U/UJ.
  - rd=0 for S/SB.
- Immediates, all sign-extended from inst[31] to XLEN:
  - I = inst[31:20].
  - S = {inst[31:25], inst[11:7]}.
  - SB = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U = {inst[31:12], 12'b0}.
  - UJ = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - R = 0.
- Latency: exactly 1 cycle from an accepted if_valid&&if_ready to the bundle at the id_* outputs when the output register is free.
- State machine (SKID_EN=1):
  - EMPTY -> FULL on accept.
  - FULL with id_ready:
    - Accept -> stays FULL with the new bundle.
    - No accept -> EMPTY.
  - FULL with !id_ready and accept -> SKID (new bundle parked in skid; if_ready=0 next cycle).
  - SKID with id_ready -> FULL; the skid bundle moves to the output, and if_ready=1 next cycle.
  - SKID never accepts.
  - if_ready = (state!=SKID), registered.
- Output hold: while id_valid && !id_ready, all id_* outputs are stable.
- Order: strictly in order; no drop or duplication.
- Flush:
  - Next state is EMPTY and id_valid=0, overriding any simultaneous accept; the accepted instruction is discarded.
  - if_ready=1 the following cycle.
- Reset mid-transfer discards all entries; no partial bundle is ever presented.
- Decode is performed before registering, so the skid holds decoded bundles.

Decomposition:
- Package rv_decode_pkg:
  - inst_t enum (R,I,S,SB,UJ,U; 3 bits).
  - Opcode localparams (OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC, OP_REG).
  - Packed struct decode_bundle_t {pc, imm, rs1, rs2, rd, type, opcode, funct3, funct7, illegal}.
- Sub-module: combinational rv_inst_decode (inst, pc -> decode_bundle_t).
- decode_stage wraps it with the output register, the skid register, and the state machine.

Test Plan:
- Immediates/fields: each inst below with id_ready=1; bundle appears 1 cycle after accept.
  - addi x1,x2,-1 (0xFFF10093) -> type=1, rs1=2, rd=1, rs2=0, imm=0xFFFFFFFF.
  - sw x5,8(x2) (0x00512423) -> type=2, rs1=2, rs2=5, rd=0, imm=0x00000008.
  - beq x0,x0,-4 (0xFE000EE3) -> type=3, imm=0xFFFFFFFC.
  - lui x3,0x12345 (0x123451B7) -> type=5, rd=3, rs1=0, imm=0x12345000.
  - jal x1,2048 (0x001000EF) -> type=4, rd=1, imm=0x00000800.
- Illegal: 0x0000007F and 0xFFFFFFFC -> id_illegal=1, type=0, rs1=rs2=rd=0, imm=0.
- Backpressure: id_ready=0, send A,B back-to-back -> if_ready=0 the cycle after B; id_* holds A stable; raise id_ready -> A then B delivered in order, if_ready returns 1.
- Streaming: if_valid=id_ready=1 for 10 words -> one bundle per cycle, pc order preserved, if_ready never drops.
- Flush in SKID state, with simultaneous if_valid -> next cycle id_valid=0, if_ready=1; no flushed pc ever appears at the output.
- Async reset asserted mid-burst, between clock edges -> id_valid=0 and all outputs 0 immediately; first instruction after release decodes correctly.
